// File: rtl/lcv_dot_acc_seq_pkg.sv
// ---------------------------------------------------------------------------
// Package lcv_dot_acc_pkg
// Shared types and constants for the streaming dot-product sequencer.
//   state_e          : sequencer state (IDLE = next beat opens a vector,
//                      RUN = mid-vector)
//   IN_W_DEF         : default signed operand width
//   ACC_W_DEF        : default signed accumulator/result width
//   LEN_W_DEF        : default beat-counter width
//   ACC_MAX/ACC_MIN  : signed limits of an ACC_W_DEF-bit accumulator
// ---------------------------------------------------------------------------
package lcv_dot_acc_pkg;

  localparam int IN_W_DEF  = 16;
  localparam int ACC_W_DEF = 33;
  localparam int LEN_W_DEF = 8;

  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/lcv_dot_acc_seq_if.sv
// ---------------------------------------------------------------------------
// Interface lcv_dot_acc_seq_if
// Operand input stream and result output stream of the dot-product sequencer.
//   in_valid/in_ready      : operand beat handshake
//   in_a, in_b             : signed operands
//   in_last                : final beat of the vector
//   bias                   : signed seed, used on the first beat only
//   out_valid/out_ready    : result handshake (result held until consumed)
//   out_sum, out_len       : result sum and saturating beat count
//   out_ovf                : sticky overflow of the reported vector
//   busy                   : vector in progress
// Modports: master = stream source/sink (testbench side), slave = sequencer.
// ---------------------------------------------------------------------------
interface lcv_dot_acc_seq_if
  import lcv_dot_acc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_a;
  logic signed [IN_W-1:0]  in_b;
  logic                    in_last;
  logic signed [ACC_W-1:0] bias;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic [LEN_W-1:0]        out_len;
  logic                    out_ovf;
  logic                    busy;

  modport master (
    output in_valid, in_a, in_b, in_last, bias, out_ready,
    input  in_ready, out_valid, out_sum, out_len, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, bias, out_ready,
    output in_ready, out_valid, out_sum, out_len, out_ovf, busy
  );

endinterface

// File: rtl/lcv_dot_acc_seq_mac.sv
// ---------------------------------------------------------------------------
// Module lcv_dot_acc_mac
// Registered signed multiply-add: sum <= a*b + c, evaluated at ACC_W+3 bits
// so that no step can lose information before the overflow check.
//   clk, rst : clock, asynchronous active-low reset
//   en_i     : load a new step result
//   a_i, b_i : signed operands (IN_W)
//   c_i      : signed addend (ACC_W)
//   sum_o    : registered wide sum (ACC_W+3)
//   ovf_o    : registered flag, sum_o lies outside the signed ACC_W range
// ---------------------------------------------------------------------------
module lcv_dot_acc_mac #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic signed [IN_W-1:0]    a_i,
  input  logic signed [IN_W-1:0]    b_i,
  input  logic signed [ACC_W-1:0]   c_i,
  output logic signed [ACC_W+2:0]   sum_o,
  output logic                      ovf_o
);

  localparam int WIDE_W = ACC_W + 3;

  logic [2*IN_W-1:0]        prod;
  logic signed [WIDE_W-1:0] sum_d;
  logic signed [WIDE_W-1:0] sum_q;
  logic [WIDE_W-ACC_W:0]    topBits;
  logic                     ovf_d;
  logic                     ovf_q;

  // Operands are sign-extended before the multiply so the low 2*IN_W bits
  // of the product are the exact two's-complement result.
  assign prod  = {{IN_W{a_i[IN_W-1]}}, a_i} * {{IN_W{b_i[IN_W-1]}}, b_i};
  assign sum_d = {{(WIDE_W-2*IN_W){prod[2*IN_W-1]}}, prod}
               + {{(WIDE_W-ACC_W){c_i[ACC_W-1]}}, c_i};

  // The value fits in ACC_W bits only if every bit from the ACC_W sign bit
  // upward is a copy of the same sign.
  assign topBits = sum_d[WIDE_W-1:ACC_W-1];
  assign ovf_d   = !((&topBits) || !(|topBits));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (en_i) begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum_o = sum_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/lcv_dot_acc_seq.sv
// ---------------------------------------------------------------------------
// Module lcv_dot_acc_seq
// Streaming signed dot-product sequencer. Accepts (a,b) beats, accumulates
// a*b on top of a per-vector bias and presents one result per vector.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   bus  : lcv_dot_acc_seq_if.slave (operand stream, result stream, busy)
// Build option: LCV_DOT_ACC_SAT_EN
//   defined     -> each step result is clamped to the signed ACC_W limits
//   not defined -> each step result wraps to ACC_W bits
//   out_ovf reports the sticky overflow in both builds.
// ---------------------------------------------------------------------------
module lcv_dot_acc_seq
  import lcv_dot_acc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input logic               clk,
  input logic               rst,
  lcv_dot_acc_seq_if.slave  bus
);

  localparam int WIDE_W = ACC_W + 3;

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]         outLen_q, outLen_d;
  logic                     outValid_q, outValid_d;
  logic                     prevOvf_q, prevOvf_d;
  logic [LEN_W-1:0]         cntStep;
  logic                     inReady;
  logic                     accept;
  logic                     firstBeat;
  logic signed [ACC_W-1:0]  accFold;
  logic signed [ACC_W-1:0]  cOperand;
  logic signed [WIDE_W-1:0] macSum;
  logic                     macOvf;
  logic                     unusedWide;

  // Beats stall whenever a result is held, so an unread result is never
  // overwritten except in the same cycle it is consumed.
  assign inReady   = !outValid_q || bus.out_ready;
  assign accept    = bus.in_valid && inReady;
  assign firstBeat = (state_q == IDLE);

  // The feedback operand is the bias on a vector's first beat and the
  // folded accumulator otherwise.
  assign cOperand = firstBeat ? bus.bias : accFold;

  assign cntStep = firstBeat  ? LEN_W'(1) :
                   (&cnt_q)   ? cnt_q     : cnt_q + LEN_W'(1);

  lcv_dot_acc_mac #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .en_i  (accept),
    .a_i   (bus.in_a),
    .b_i   (bus.in_b),
    .c_i   (cOperand),
    .sum_o (macSum),
    .ovf_o (macOvf)
  );

  // The MAC register keeps the wide step result; the accumulator seen by the
  // feedback path and the output is that value folded back to ACC_W bits.
  assign unusedWide = ^macSum[WIDE_W-1:ACC_W];

`ifdef LCV_DOT_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  always_comb begin
    accFold = macSum[ACC_W-1:0];
    if (macOvf) begin
      accFold = macSum[WIDE_W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  always_comb begin
    accFold = macSum[ACC_W-1:0];
  end
`endif

  // Next-state logic: FSM, beat counter, sticky overflow and output handshake.
  // prevOvf_q collects the overflow of all earlier steps of the vector; the
  // MAC's own flag supplies the most recent step.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    outLen_d   = outLen_q;
    outValid_d = outValid_q;
    prevOvf_d  = prevOvf_q;

    if (outValid_q && bus.out_ready) begin
      outValid_d = 1'b0;
    end

    if (accept) begin
      cnt_d     = cntStep;
      prevOvf_d = firstBeat ? 1'b0 : (prevOvf_q | macOvf);
      if (bus.in_last) begin
        state_d    = IDLE;
        outLen_d   = cntStep;
        outValid_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      outLen_q   <= '0;
      outValid_q <= 1'b0;
      prevOvf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      outLen_q   <= outLen_d;
      outValid_q <= outValid_d;
      prevOvf_q  <= prevOvf_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.out_sum   = accFold;
  assign bus.out_len   = outLen_q;
  assign bus.out_ovf   = prevOvf_q | macOvf;
  assign bus.busy      = (state_q == RUN);

endmodule

// File: tb/tb_lcv_dot_acc_seq.sv
// ---------------------------------------------------------------------------
// Testbench tb_lcv_dot_acc_seq
// Directed vectors with hand-computed sums for lcv_dot_acc_seq, covering
// normal accumulation, single-beat vectors, overflow in both directions,
// output back-pressure, drain-and-replace, counter saturation and reset
// in mid-vector. Expected values follow LCV_DOT_ACC_SAT_EN when defined.
// ---------------------------------------------------------------------------
module tb_lcv_dot_acc_seq;
  import lcv_dot_acc_pkg::*;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  lcv_dot_acc_seq_if #(.IN_W(16), .ACC_W(33), .LEN_W(8)) bus ();

  lcv_dot_acc_seq #(.IN_W(16), .ACC_W(33), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison funnels through here so the counts stay in one place.
  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Presents one beat, waits (bounded) for in_ready, and returns one time
  // step after the edge that accepted it.
  task automatic applyStimulus(input int a, input int b, input logic last,
                               input longint biasV);
    int waitCycles;
    bus.in_valid = 1'b1;
    bus.in_a     = a[15:0];
    bus.in_b     = b[15:0];
    bus.in_last  = last;
    bus.bias     = biasV[32:0];
    waitCycles   = 0;
    while (!bus.in_ready && waitCycles < 50) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput("inReady", 64'(bus.in_ready), 64'sd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic checkResult(input string tag, input longint expSum,
                             input int expLen, input logic expOvf);
    checkOutput({tag, ".valid"}, 64'(bus.out_valid), 64'sd1);
    checkOutput({tag, ".sum"},   64'(bus.out_sum),   expSum);
    checkOutput({tag, ".len"},   64'(bus.out_len),   64'(expLen));
    checkOutput({tag, ".ovf"},   64'(bus.out_ovf),   64'(expOvf));
  endtask

  // Safety net in case the design never lets a test finish.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount    = 0;
    errorCount    = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.bias      = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.outValid", 64'(bus.out_valid), 64'sd0);
    checkOutput("rst.busy",     64'(bus.busy),      64'sd0);
    checkOutput("rst.outSum",   64'(bus.out_sum),   64'sd0);
    checkOutput("rst.outLen",   64'(bus.out_len),   64'sd0);
    checkOutput("rst.outOvf",   64'(bus.out_ovf),   64'sd0);
    checkOutput("rst.inReady",  64'(bus.in_ready),  64'sd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Three-beat vector: 10 + 12 - 10 + 49 = 61. Mid-vector bias is ignored.
    $display("[TB] three-beat vector");
    applyStimulus(3, 4, 1'b0, 10);
    checkOutput("t1.busy",     64'(bus.busy),      64'sd1);
    checkOutput("t1.noValid1", 64'(bus.out_valid), 64'sd0);
    applyStimulus(-2, 5, 1'b0, 999);
    checkOutput("t1.noValid2", 64'(bus.out_valid), 64'sd0);
    applyStimulus(7, 7, 1'b1, 999);
    checkResult("t1", 61, 3, 1'b0);
    checkOutput("t1.idle", 64'(bus.busy), 64'sd0);
    @(posedge clk); #1;
    checkOutput("t1.drained", 64'(bus.out_valid), 64'sd0);

    // Single-beat vector with the most negative operands.
    $display("[TB] single-beat vector");
    applyStimulus(-32768, -32768, 1'b1, 0);
    checkResult("t2", 64'sd1073741824, 1, 1'b0);
    @(posedge clk); #1;

    // Positive overflow: 4294967295 + 1073676289 exceeds 2^32-1.
    $display("[TB] positive overflow");
    applyStimulus(32767, 32767, 1'b1, longint'(ACC_MAX));
`ifdef LCV_DOT_ACC_SAT_EN
    checkResult("t3", 64'sd4294967295, 1, 1'b1);
`else
    checkResult("t3", -64'sd3221291008, 1, 1'b1);
`endif
    @(posedge clk); #1;

    // Negative overflow: -4294967296 - 1073709056 is below -2^32.
    $display("[TB] negative overflow");
    applyStimulus(32767, -32768, 1'b1, longint'(ACC_MIN));
`ifdef LCV_DOT_ACC_SAT_EN
    checkResult("t7", -64'sd4294967296, 1, 1'b1);
`else
    checkResult("t7", 64'sd3221258240, 1, 1'b1);
`endif
    @(posedge clk); #1;

    // Back-pressure: a held result blocks every beat until it is consumed.
    $display("[TB] output back-pressure");
    bus.out_ready = 1'b0;
    applyStimulus(2, 2, 1'b1, 1);
    checkResult("t4.held", 5, 1, 1'b0);
    checkOutput("t4.inReadyLow", 64'(bus.in_ready), 64'sd0);
    bus.in_valid = 1'b1;
    bus.in_a     = 16'sd1;
    bus.in_b     = 16'sd1;
    bus.in_last  = 1'b0;
    bus.bias     = 33'sd100;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4.stillValid", 64'(bus.out_valid), 64'sd1);
    checkOutput("t4.stillSum",   64'(bus.out_sum),   64'sd5);
    checkOutput("t4.notBusy",    64'(bus.busy),      64'sd0);
    bus.out_ready = 1'b1;
    #1;
    checkOutput("t4.inReadyHigh", 64'(bus.in_ready), 64'sd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("t4.drained", 64'(bus.out_valid), 64'sd0);
    checkOutput("t4.busy",    64'(bus.busy),      64'sd1);
    applyStimulus(3, 3, 1'b1, 0);
    checkResult("t4.next", 110, 2, 1'b0);
    @(posedge clk); #1;

    // Drain and a new single-beat result in the same cycle.
    $display("[TB] drain and replace");
    bus.out_ready = 1'b0;
    applyStimulus(4, 4, 1'b1, 1);
    checkResult("t5.old", 17, 1, 1'b0);
    bus.out_ready = 1'b1;
    applyStimulus(2, 3, 1'b1, 0);
    checkResult("t5.new", 6, 1, 1'b0);
    @(posedge clk); #1;
    checkOutput("t5.drained", 64'(bus.out_valid), 64'sd0);

    // 260 beats of 1*1: the count saturates at 255, the sum does not.
    $display("[TB] beat counter saturation");
    for (int i = 0; i < 259; i++) begin
      applyStimulus(1, 1, 1'b0, 0);
    end
    applyStimulus(1, 1, 1'b1, 0);
    checkResult("sat", 260, 255, 1'b0);
    @(posedge clk); #1;

    // Reset in mid-vector discards the partial accumulation.
    $display("[TB] reset mid-vector");
    applyStimulus(5, 5, 1'b0, 50);
    applyStimulus(6, 6, 1'b0, 0);
    checkOutput("t6.busyBefore", 64'(bus.busy), 64'sd1);
    rst = 1'b0;
    #1;
    checkOutput("t6.outValid", 64'(bus.out_valid), 64'sd0);
    checkOutput("t6.busy",     64'(bus.busy),      64'sd0);
    checkOutput("t6.outSum",   64'(bus.out_sum),   64'sd0);
    checkOutput("t6.outLen",   64'(bus.out_len),   64'sd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1, 1, 1'b1, 5);
    checkResult("t6.after", 6, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
